csr_unit: RTL and testbench
===========================

# csr_unit

Parametrised machine-mode CSR and trap unit for the NPC core. It replaces the core's fixed mtvec/mepc/mcause/mstatus registers and their fixed write sources. It implements read-modify-write CSR operations, ecall/exception trap entry with MIE/MPIE stacking, mret return, and 64-bit mcycle/minstret counters. It sits beside the register file: the decoder drives the CSR command, and the PC unit consumes the redirect outputs.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- HAS_COUNTERS, 1, when 0, counter CSRs read 0 and their accesses are illegal.
- MSTATUS_RESET, 32'h0000_1800, reset value of mstatus (MPP=11, MIE=0).
- MTVEC_RESET, 0, reset value of mtvec.
- MARCHID, 0, constant returned by marchid.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- csr_addr  in  12  CSR address.
- csr_op  in  2  00 none, 01 CSRRW, 10 CSRRS, 11 CSRRC.
- csr_wsrc  in  XLEN  rs1 value or zero-extended zimm.
- csr_rdata  out  XLEN  old CSR value (combinational), written to rd by the core.
- csr_illegal  out  1  the current access is illegal (combinational).
- inst_retire  in  1  one instruction retires this cycle.
- exc_valid  in  1  take a trap this cycle.
- exc_cause  in  5  exception code (ecall=11, illegal=2, breakpoint=3).
- trap_pc  in  XLEN  PC of the trapping instruction.
- mret  in  1  an mret executes this cycle.
- redirect  out  1  the PC must load redirect_pc at the next edge.
- redirect_pc  out  XLEN  trap vector or mepc.
- mie_out  out  1  current mstatus.MIE.

## Operation
Implemented CSRs:
- mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 11; other bits read 0.
- mtvec 0x305: direct mode only; bits [1:0] are forced to 0 on write.
- mscratch 0x340.
- mepc 0x341: bits [1:0] are forced to 0.
- mcause 0x342: written with the full width; the interrupt bit is always 0 on trap entry.
- mcycle 0xB00 and minstret 0xB02: low halves. When XLEN=32, the high halves are mcycleh 0xB80 and minstreth 0xB82. When XLEN=64, 0xB80 and 0xB82 are illegal.
- mvendorid 0xF11 reads 0; marchid 0xF12 reads MARCHID. Both are read-only.

Write value:
- CSRRW: wsrc.
- CSRRS: old | wsrc.
- CSRRC: old & ~wsrc.
- CSRRS or CSRRC with wsrc==0 is a pure read: no state change, and it is legal on read-only CSRs.

csr_illegal=1 when csr_op!=0 and any of the following holds:
- the address is unimplemented;
- the access is a write to 0xF1x;
- the access targets a counter CSR with HAS_COUNTERS=0.

An illegal access changes no state. The core raises exc_valid with cause 2 itself.

Priority per cycle: exc_valid > mret > CSR write.
- Trap entry (exc_valid):
  - mepc<=trap_pc&~3, mcause<=zext(exc_cause), MPIE<=MIE, MIE<=0.
  - redirect=1, redirect_pc={mtvec[XLEN-1:2],2'b00}.
  - A concurrent CSR write and mret are suppressed.
- mret, when exc_valid=0: MIE<=MPIE, MPIE<=1, redirect=1, redirect_pc=mepc (the current value).
- Otherwise redirect=0 and redirect_pc=0.

Counters (64-bit each):
- mcycle increments by 1 every cycle.
- minstret increments by 1 when inst_retire=1.
- A CSR write to either half of a counter replaces that half and suppresses that counter's increment for the cycle. The other half holds.
- Wrap from all-ones to 0 is silent.
- csr_rdata for counters returns the pre-increment value.

## Timing
- csr_rdata, csr_illegal, redirect, redirect_pc and mie_out are combinational from the current state and inputs. No input-to-output path passes through csr_rdata except via csr_addr.
- All CSR updates occur at posedge clk. A read in the cycle after a write returns the new value.
- Reset, asynchronous:
  - mstatus=MSTATUS_RESET, mtvec=MTVEC_RESET; mepc, mcause, mscratch, mcycle and minstret are 0.
  - Outputs follow from those values.
  - Reset asserted mid-operation discards any pending update, including a trap in the same cycle.
- The first mcycle increment occurs at the first posedge after rst deasserts.

## Test plan
- Reset, then CSRRS x0 on 0x300 → csr_rdata=0x1800. Cycle 5 after reset, read 0xB00 → 5. Read 0xB80 → 0.
- CSRRW 0x305 with wsrc=0x8000_0103 → next read returns 0x8000_0100. Then exc_valid with cause 11 and trap_pc=0x8000_0044 in the same cycle as CSRRW 0x340 → redirect=1, redirect_pc=0x8000_0100, mepc=0x8000_0044, mcause=11, mscratch unchanged.
- CSRRS 0x300 with wsrc=0x8 (MIE=1), then trap → mstatus=0x1880. Then mret → redirect_pc=mepc, mstatus=0x1888.
- CSRRW 0xF11 with wsrc=1 → csr_illegal=1, no state change. CSRRS 0xF12 with wsrc=0 → legal, returns MARCHID. Access to 0x7C0 → csr_illegal=1.
- Write mcycle=0xFFFF_FFFF, then one cycle later → mcycle=0, mcycleh=1. Write minstreth with inst_retire=1 in the same cycle → minstret unchanged that cycle.
- exc_valid and mret asserted together → trap entry only; MPIE takes the old MIE.

Source files
------------

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_unit
// Purpose  : Machine-mode CSR file and trap unit. Performs CSRRW/CSRRS/CSRRC
//            read-modify-write, trap entry with MIE/MPIE stacking, mret
//            return, and 64-bit mcycle/minstret counters.
// Revision : 1.0 - initial release
// ============================================================================
module csr_unit #(
    parameter int              XLEN          = 32,
    parameter bit              HAS_COUNTERS  = 1'b1,
    parameter logic [31:0]     MSTATUS_RESET = 32'h0000_1800,
    parameter logic [XLEN-1:0] MTVEC_RESET   = '0,
    parameter logic [XLEN-1:0] MARCHID       = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wsrc,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            inst_retire,
    input  logic            exc_valid,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mie_out
);

    localparam logic [1:0]  OP_NONE = 2'b00;
    localparam logic [1:0]  OP_RW   = 2'b01;
    localparam logic [1:0]  OP_RS   = 2'b10;
    localparam logic [1:0]  OP_RC   = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    // Architectural state
    logic            mie_q,      mie_d;
    logic            mpie_q,     mpie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [63:0]     mcycle_q,   mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    // Decode / datapath wires
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_wval;
    logic [XLEN-1:0] w_cyc_lo;
    logic [XLEN-1:0] w_cyc_hi;
    logic [XLEN-1:0] w_ins_lo;
    logic [XLEN-1:0] w_ins_hi;
    logic            w_impl;
    logic            w_is_cnt;
    logic            w_ro;
    logic            w_wr_req;
    logic            w_illegal;
    logic            w_wen;

    assign w_cyc_lo = mcycle_q[XLEN-1:0];
    assign w_ins_lo = minstret_q[XLEN-1:0];

    // Upper counter halves are only addressable as separate CSRs on RV32
    generate
        if (XLEN == 32) begin : g_cnt_hi32
            assign w_cyc_hi = mcycle_q[63:32];
            assign w_ins_hi = minstret_q[63:32];
        end else begin : g_cnt_hi64
            assign w_cyc_hi = '0;
            assign w_ins_hi = '0;
        end
    endgenerate

    // Assemble mstatus view: MPP hardwired to M-mode, only MIE/MPIE are live
    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = mpie_q;
        w_mstatus[3]     = mie_q;
    end

    // Address decode: read mux plus implemented / read-only / counter flags
    always_comb begin
        w_rdata  = '0;
        w_impl   = 1'b0;
        w_is_cnt = 1'b0;
        w_ro     = 1'b0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                w_impl  = 1'b1;
                w_rdata = w_mstatus;
            end
            ADDR_MTVEC: begin
                w_impl  = 1'b1;
                w_rdata = mtvec_q;
            end
            ADDR_MSCRATCH: begin
                w_impl  = 1'b1;
                w_rdata = mscratch_q;
            end
            ADDR_MEPC: begin
                w_impl  = 1'b1;
                w_rdata = mepc_q;
            end
            ADDR_MCAUSE: begin
                w_impl  = 1'b1;
                w_rdata = mcause_q;
            end
            ADDR_MCYCLE: begin
                w_impl   = 1'b1;
                w_is_cnt = 1'b1;
                w_rdata  = HAS_COUNTERS ? w_cyc_lo : '0;
            end
            ADDR_MINSTRET: begin
                w_impl   = 1'b1;
                w_is_cnt = 1'b1;
                w_rdata  = HAS_COUNTERS ? w_ins_lo : '0;
            end
            ADDR_MCYCLEH: begin
                if (XLEN == 32) begin
                    w_impl   = 1'b1;
                    w_is_cnt = 1'b1;
                    w_rdata  = HAS_COUNTERS ? w_cyc_hi : '0;
                end
            end
            ADDR_MINSTRETH: begin
                if (XLEN == 32) begin
                    w_impl   = 1'b1;
                    w_is_cnt = 1'b1;
                    w_rdata  = HAS_COUNTERS ? w_ins_hi : '0;
                end
            end
            ADDR_MVENDORID: begin
                w_impl = 1'b1;
                w_ro   = 1'b1;
            end
            ADDR_MARCHID: begin
                w_impl  = 1'b1;
                w_ro    = 1'b1;
                w_rdata = MARCHID;
            end
            default: ;
        endcase
    end

    // Write intent, legality and the read-modify-write value
    always_comb begin
        w_wr_req  = (csr_op == OP_RW) ||
                    (((csr_op == OP_RS) || (csr_op == OP_RC)) && (|csr_wsrc));
        w_illegal = (csr_op != OP_NONE) &&
                    (!w_impl || (w_ro && w_wr_req) || (w_is_cnt && !HAS_COUNTERS));
        case (csr_op)
            OP_RS:   w_wval = w_rdata | csr_wsrc;
            OP_RC:   w_wval = w_rdata & ~csr_wsrc;
            default: w_wval = csr_wsrc;
        endcase
        // Traps and mret take precedence over any CSR write in the same cycle
        w_wen = w_wr_req && !w_illegal && !exc_valid && !mret;
    end

    assign csr_rdata   = w_rdata;
    assign csr_illegal = w_illegal;
    assign mie_out     = mie_q;

    // PC redirect on trap entry (to mtvec) or mret (to current mepc)
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        if (exc_valid) begin
            redirect    = 1'b1;
            redirect_pc = {mtvec_q[XLEN-1:2], 2'b00};
        end else if (mret) begin
            redirect    = 1'b1;
            redirect_pc = mepc_q;
        end
    end

    // Next-state for status/trap CSRs: trap > mret > CSR write
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (exc_valid) begin
            mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d = XLEN'(exc_cause);
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (w_wen) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = w_wval[3];
                    mpie_d = w_wval[7];
                end
                ADDR_MTVEC:    mtvec_d    = {w_wval[XLEN-1:2], 2'b00};
                ADDR_MSCRATCH: mscratch_d = w_wval;
                ADDR_MEPC:     mepc_d     = {w_wval[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_d   = w_wval;
                default: ;
            endcase
        end
    end

    // Next-state for counters: a write to a half replaces it and skips the tick
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = inst_retire ? (minstret_q + 64'd1) : minstret_q;
        if (w_wen) begin
            case (csr_addr)
                ADDR_MCYCLE: begin
                    if (XLEN == 32) mcycle_d = {mcycle_q[63:32], w_wval[31:0]};
                    else            mcycle_d = 64'(w_wval);
                end
                ADDR_MINSTRET: begin
                    if (XLEN == 32) minstret_d = {minstret_q[63:32], w_wval[31:0]};
                    else            minstret_d = 64'(w_wval);
                end
                ADDR_MCYCLEH:   mcycle_d   = {w_wval[31:0], mcycle_q[31:0]};
                ADDR_MINSTRETH: minstret_d = {w_wval[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    // State registers; asynchronous reset drops any update pending this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= MSTATUS_RESET[3];
            mpie_q     <= MSTATUS_RESET[7];
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_unit
// Purpose  : Scoreboard bench for csr_unit. Stimulus pushes expected output
//            values tagged with their cycle; a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_unit;

    localparam int          XLEN = 32;
    localparam logic [31:0] ARCH = 32'h0000_0042;

    localparam int K_RDATA = 0;
    localparam int K_ILL   = 1;
    localparam int K_RED   = 2;
    localparam int K_RPC   = 3;
    localparam int K_MIE   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [11:0]     csr_addr = '0;
    logic [1:0]      csr_op = '0;
    logic [XLEN-1:0] csr_wsrc = '0;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            inst_retire = 1'b0;
    logic            exc_valid = 1'b0;
    logic [4:0]      exc_cause = '0;
    logic [XLEN-1:0] trap_pc = '0;
    logic            mret = 1'b0;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            mie_out;

    csr_unit #(
        .XLEN          (XLEN),
        .HAS_COUNTERS  (1'b1),
        .MSTATUS_RESET (32'h0000_1800),
        .MTVEC_RESET   (32'h0),
        .MARCHID       (ARCH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wsrc    (csr_wsrc),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .inst_retire (inst_retire),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .trap_pc     (trap_pc),
        .mret        (mret),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mie_out     (mie_out)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RDATA: return csr_rdata;
            K_ILL:   return {31'b0, csr_illegal};
            K_RED:   return {31'b0, redirect};
            K_RPC:   return redirect_pc;
            default: return {31'b0, mie_out};
        endcase
    endfunction

    // Monitor: compare every expectation tagged for the current cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.kind);
            total++;
            if (e.cyc != cyc || act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h (cycle %0d, tagged %0d)",
                         e.name, act, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input int kind, input string name, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Start a new cycle with all command inputs idle
    task automatic next_cycle();
        @(posedge clk);
        #1;
        csr_op      = 2'b00;
        csr_wsrc    = '0;
        exc_valid   = 1'b0;
        mret        = 1'b0;
        inst_retire = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input string name, input logic [31:0] v);
        next_cycle();
        csr_addr = a;
        csr_op   = 2'b10;
        push_exp(K_RDATA, name, v);
        push_exp(K_ILL, {name, "_ill"}, 32'd0);
    endtask

    initial begin
        // --- reset state ---
        next_cycle();
        csr_addr = 12'hB00; csr_op = 2'b10;
        push_exp(K_RDATA, "rst_mcycle", 32'd0);
        push_exp(K_RED, "rst_redirect", 32'd0);
        push_exp(K_MIE, "rst_mie", 32'd0);

        next_cycle();
        rst = 1'b0;
        csr_addr = 12'h300; csr_op = 2'b10;
        push_exp(K_RDATA, "rst_mstatus", 32'h1800);
        push_exp(K_ILL, "rst_mstatus_ill", 32'd0);

        // --- mcycle counts posedges after reset release ---
        for (int i = 1; i <= 5; i++) rd(12'hB00, "mcycle_run", 32'(i));
        rd(12'hB80, "mcycleh_zero", 32'd0);

        // --- mtvec write masks low bits ---
        next_cycle();
        csr_addr = 12'h305; csr_op = 2'b01; csr_wsrc = 32'h8000_0103;
        push_exp(K_RDATA, "mtvec_old", 32'd0);
        rd(12'h305, "mtvec_new", 32'h8000_0100);

        // --- trap with concurrent mscratch write ---
        next_cycle();
        csr_addr = 12'h340; csr_op = 2'b01; csr_wsrc = 32'hDEAD_BEEF;
        exc_valid = 1'b1; exc_cause = 5'd11; trap_pc = 32'h8000_0044;
        push_exp(K_RED, "trap1_redirect", 32'd1);
        push_exp(K_RPC, "trap1_pc", 32'h8000_0100);
        rd(12'h341, "trap1_mepc", 32'h8000_0044);
        push_exp(K_RED, "idle_redirect", 32'd0);
        push_exp(K_RPC, "idle_rpc", 32'd0);
        rd(12'h342, "trap1_mcause", 32'd11);
        rd(12'h340, "mscratch_kept", 32'd0);

        // --- MIE set, trap stacks it, mret restores ---
        next_cycle();
        csr_addr = 12'h300; csr_op = 2'b10; csr_wsrc = 32'h8;
        push_exp(K_RDATA, "mie_set_old", 32'h1800);
        rd(12'h300, "mie_set_new", 32'h1808);
        push_exp(K_MIE, "mie_out_on", 32'd1);

        next_cycle();
        exc_valid = 1'b1; exc_cause = 5'd3; trap_pc = 32'h8000_0080;
        push_exp(K_RPC, "trap2_pc", 32'h8000_0100);
        push_exp(K_MIE, "trap2_mie_pre", 32'd1);
        rd(12'h300, "trap2_mstatus", 32'h1880);
        push_exp(K_MIE, "trap2_mie_post", 32'd0);

        next_cycle();
        mret = 1'b1; csr_addr = 12'h341; csr_op = 2'b10;
        push_exp(K_RDATA, "mret_mepc", 32'h8000_0080);
        push_exp(K_RED, "mret_redirect", 32'd1);
        push_exp(K_RPC, "mret_pc", 32'h8000_0080);
        rd(12'h300, "mret_mstatus", 32'h1888);
        push_exp(K_MIE, "mret_mie", 32'd1);

        // --- trap and mret together: trap wins ---
        next_cycle();
        exc_valid = 1'b1; mret = 1'b1; exc_cause = 5'd2; trap_pc = 32'h8000_0101;
        push_exp(K_RPC, "both_pc", 32'h8000_0100);
        rd(12'h300, "both_mstatus", 32'h1880);
        rd(12'h341, "both_mepc", 32'h8000_0100);
        rd(12'h342, "both_mcause", 32'd2);

        // --- illegal / read-only accesses ---
        next_cycle();
        csr_addr = 12'hF11; csr_op = 2'b01; csr_wsrc = 32'd1;
        push_exp(K_ILL, "mvendorid_wr_ill", 32'd1);
        push_exp(K_RDATA, "mvendorid_rd", 32'd0);
        rd(12'hF12, "marchid", ARCH);
        next_cycle();
        csr_addr = 12'hF12; csr_op = 2'b11; csr_wsrc = 32'h2;
        push_exp(K_ILL, "marchid_clr_ill", 32'd1);
        next_cycle();
        csr_addr = 12'h7C0; csr_op = 2'b10;
        push_exp(K_ILL, "unimpl_ill", 32'd1);
        next_cycle();
        csr_addr = 12'h7C0; csr_op = 2'b00;
        push_exp(K_ILL, "unimpl_noop", 32'd0);
        next_cycle();
        csr_addr = 12'h300; csr_op = 2'b01; csr_wsrc = 32'h0;
        exc_valid = 1'b0;
        push_exp(K_ILL, "mstatus_rw_legal", 32'd0);
        rd(12'h300, "mstatus_cleared", 32'h1800);

        // --- mcycle carry into high half ---
        next_cycle();
        csr_addr = 12'hB00; csr_op = 2'b01; csr_wsrc = 32'hFFFF_FFFF;
        push_exp(K_ILL, "mcycle_wr_ill", 32'd0);
        rd(12'hB00, "mcycle_written", 32'hFFFF_FFFF);
        rd(12'hB00, "mcycle_wrap", 32'd0);
        rd(12'hB80, "mcycleh_carry", 32'd1);

        // --- minstret write/increment interaction ---
        next_cycle();
        csr_addr = 12'hB02; csr_op = 2'b01; csr_wsrc = 32'h10;
        next_cycle();
        csr_addr = 12'hB02; csr_op = 2'b10; inst_retire = 1'b1;
        push_exp(K_RDATA, "minstret_wr", 32'h10);
        next_cycle();
        csr_addr = 12'hB82; csr_op = 2'b01; csr_wsrc = 32'd7; inst_retire = 1'b1;
        push_exp(K_RDATA, "minstreth_old", 32'd0);
        rd(12'hB02, "minstret_held", 32'h11);
        rd(12'hB82, "minstreth_new", 32'd7);

        // --- reset mid-operation discards a concurrent trap ---
        next_cycle();
        exc_valid = 1'b1; exc_cause = 5'd11; trap_pc = 32'h1234_5678;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        csr_addr = 12'h342; csr_op = 2'b10;
        push_exp(K_RDATA, "midrst_mcause", 32'd0);
        rd(12'h305, "midrst_mtvec", 32'd0);
        rd(12'h341, "midrst_mepc", 32'd0);
        rd(12'h300, "midrst_mstatus", 32'h1800);

        next_cycle();
        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
